// File: rtl/risc_control_fsm_pkg.sv
// Shared definitions for the RISC control sequencer: opcodes, state encoding,
// PC update selectors, write-back source codes and opcode classifiers.
package risc_control_fsm_pkg;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_INV  = 4'h4;
    localparam logic [3:0] OP_LSL  = 4'h5;
    localparam logic [3:0] OP_LSR  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_RESET,
        PC_INC,
        PC_BRANCH,
        PC_JUMP
    } pc_op_t;

    function automatic logic is_alu(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_INV, OP_LSL, OP_LSR,
            OP_AND, OP_OR, OP_SLT: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/risc_control_fsm_pc_unit.sv
// Program counter register with its next-pc selection (hold/reset/increment/branch/jump).
module risc_control_fsm_pc_unit
    import risc_control_fsm_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_op_t      pc_op,
    input  logic [11:0] field,
    output logic [15:0] pc
);

    logic [15:0] pc_plus1;
    logic [15:0] offset;
    logic [15:0] pc_next;

    assign pc_plus1 = pc + 16'd1;
    assign offset   = {{10{field[5]}}, field[5:0]};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        pc_next = pc;
        unique case (pc_op)
            PC_HOLD:   pc_next = pc;
            PC_RESET:  pc_next = RESET_PC;
            PC_INC:    pc_next = pc_plus1;
            PC_BRANCH: pc_next = pc_plus1 + offset;
            PC_JUMP:   pc_next = {pc_plus1[15:12], field};
            default:   pc_next = pc;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) pc <= RESET_PC;
        else     pc <= pc_next;
    end

endmodule

// File: rtl/risc_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit RISC core: owns the PC and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB by handshaking with the datapath units.
module risc_control_fsm
    import risc_control_fsm_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          WD_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        inst_valid,
    input  logic [15:0] instruction,
    input  logic        alu_done,
    input  logic        alu_zero,
    input  logic        mem_done,
    output logic [15:0] pc,
    output logic        inst_req,
    output logic        decode_en,
    output logic [3:0]  opcode,
    output logic        alu_start,
    output logic        mem_read,
    output logic        mem_write,
    output logic        wb_en,
    output logic        wb_sel,
    output logic [2:0]  wb_addr,
    output logic        busy,
    output logic        halted,
    output logic        fault
);

    localparam int WD_W = $clog2(WD_CYCLES);

    state_t          state, state_next;
    pc_op_t          pc_op;
    logic [15:0]     ir;
    logic [3:0]      op;
    logic [WD_W-1:0] wd_cnt;
    logic            fault_q;
    logic            fault_set;
    logic            waiting;
    logic            handshake;
    logic            wd_expire;

    assign op = ir[15:12];

    risc_control_fsm_pc_unit #(.RESET_PC(RESET_PC)) u_pc (
        .clk   (clk),
        .rst   (rst),
        .pc_op (pc_op),
        .field (ir[11:0]),
        .pc    (pc)
    );

    assign waiting   = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
    assign handshake = ((state == S_FETCH) && inst_valid) ||
                       ((state == S_EXEC)  && alu_done)   ||
                       ((state == S_MEM)   && mem_done);
    // A handshake arriving on the last permitted cycle still wins over the watchdog.
    assign wd_expire = waiting && !handshake && (wd_cnt == WD_W'(WD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pc_op      = PC_HOLD;
        fault_set  = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                state_next = S_FETCH;
                pc_op      = PC_RESET;
            end
            S_FETCH: if (inst_valid) state_next = S_DECODE;
            S_DECODE: begin
                if (op == OP_JMP) begin
                    state_next = S_FETCH;
                    pc_op      = PC_JUMP;
                end else if (op == OP_HALT) begin
                    state_next = S_HALT;
                end else if (is_alu(op) || is_branch(op) || is_mem(op)) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_HALT;
                    fault_set  = 1'b1;
                end
            end
            S_EXEC: if (alu_done) begin
                if (is_mem(op)) begin
                    state_next = S_MEM;
                end else if (is_branch(op)) begin
                    state_next = S_FETCH;
                    pc_op      = (alu_zero ^ (op == OP_BNE)) ? PC_BRANCH : PC_INC;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: if (mem_done) begin
                if (op == OP_LD) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_FETCH;
                    pc_op      = PC_INC;
                end
            end
            S_WB: begin
                state_next = S_FETCH;
                pc_op      = PC_INC;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
        if (wd_expire) begin
            state_next = S_HALT;
            pc_op      = PC_HOLD;
            fault_set  = 1'b1;
        end
    end

    // Watchdog restarts on every state change, so it is zero on the first cycle of each state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir      <= '0;
            wd_cnt  <= '0;
            fault_q <= 1'b0;
        end else begin
            if ((state == S_FETCH) && inst_valid) ir <= instruction;
            if (state_next != state) wd_cnt <= '0;
            else if (waiting)        wd_cnt <= wd_cnt + WD_W'(1);
            if (fault_set) fault_q <= 1'b1;
        end
    end

    always_comb begin
        inst_req  = 1'b0;
        decode_en = 1'b0;
        alu_start = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wb_en     = 1'b0;
        wb_sel    = WB_ALU;
        wb_addr   = 3'd0;
        unique case (state)
            S_FETCH:  inst_req  = 1'b1;
            S_DECODE: decode_en = 1'b1;
            S_EXEC:   alu_start = (wd_cnt == '0);
            S_MEM: begin
                mem_read  = (op == OP_LD);
                mem_write = (op == OP_ST);
            end
            S_WB: begin
                wb_en   = 1'b1;
                wb_sel  = (op == OP_LD) ? WB_MEM : WB_ALU;
                wb_addr = (op == OP_LD) ? ir[8:6] : ir[5:3];
            end
            default: ;
        endcase
    end

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);
    assign fault  = fault_q;
    assign opcode = op;

endmodule
